// File: rtl/request_client_pkg.sv
// request_client_pkg
// Shared definitions for the request/grant client:
//   - chan_state_e : per-channel FSM state (IDLE, REQ, USE, REL)
//   - hold_width() : hold-counter width, $clog2(hold) with a floor of 1
//   - HOLD_CYCLES_DEFAULT / HOLD_W_DEFAULT : default hold window and width
package request_client_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_USE  = 2'd2,
    ST_REL  = 2'd3
  } chan_state_e;

  // The counter is loaded with hold-1, so $clog2(hold) bits always suffice.
  function automatic int unsigned hold_width(input int unsigned hold);
    if (hold > 1) return $unsigned($clog2(hold));
    return 1;
  endfunction

  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
  localparam int unsigned HOLD_W_DEFAULT      = hold_width(HOLD_CYCLES_DEFAULT);

endpackage

// File: rtl/request_channel.sv
// request_channel
// One requester channel: pending-job counter, request FSM and hold counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_job       : one-cycle pulse, enqueue one job
//   i_grant     : grant from the arbiter for this channel
//   o_req       : request to the arbiter (registered)
//   o_busy      : channel is using the resource (registered)
//   o_done      : one-cycle job-completion pulse (registered)
//   o_pend      : pending jobs, including the one in progress
//   o_ovf       : sticky, a job arrived while the counter was full
//   o_err       : sticky, grant in IDLE or grant revoked during USE
module request_channel
  import request_client_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_job,
  input  logic             i_grant,
  output logic             o_req,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pend,
  output logic             o_ovf,
  output logic             o_err
);

  localparam int unsigned       HOLD_W    = hold_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;

  chan_state_e       r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_pend;
  logic              r_req;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic              r_err;
  logic              w_complete;

  // A job completes only on a clean final USE cycle; a revoked grant aborts
  // without completing so the job stays queued for retry.
  assign w_complete = (r_state == ST_USE) && i_grant && (r_hold == '0);

  // NOTE: all sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else if (i_job && !w_complete) begin
      if (r_pend == PEND_MAX) r_ovf  <= 1'b1;
      else                    r_pend <= r_pend + 1'b1;
    end else if (!i_job && w_complete) begin
      r_pend <= r_pend - 1'b1;
    end
    // job together with completion: count unchanged
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_grant) r_err <= 1'b1;
          if (r_pend != '0) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_grant) begin
            r_state <= ST_USE;
            r_busy  <= 1'b1;
            r_hold  <= HOLD_LOAD;
          end
        end
        ST_USE: begin
          if (!i_grant) begin
            r_err   <= 1'b1;
            r_state <= ST_REL;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_hold == '0) begin
            r_state <= ST_REL;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        // Grant may still be high here: the arbiter lags by one cycle.
        ST_REL:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req  = r_req;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;
  assign o_err  = r_err;

endmodule

// File: rtl/request_client.sv
// request_client
// Two-channel requester agent for a request/grant arbiter.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_job0, i_job1      : one-cycle job-enqueue pulses per channel
//   i_g0, i_g1          : grants from the arbiter
//   o_r0, o_r1          : requests to the arbiter
//   o_busy0, o_busy1    : channel holds the resource
//   o_done0, o_done1    : job-completion pulses
//   o_pend0, o_pend1    : pending-job counts
//   o_ovf               : sticky, a job was dropped on a full counter
//   o_err               : sticky, grant protocol violation
module request_client
  import request_client_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_job0,
  input  logic             i_job1,
  input  logic             i_g0,
  input  logic             i_g1,
  output logic             o_r0,
  output logic             o_r1,
  output logic             o_busy0,
  output logic             o_busy1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [CNT_W-1:0] o_pend0,
  output logic [CNT_W-1:0] o_pend1,
  output logic             o_ovf,
  output logic             o_err
);

  logic w_ovf0, w_ovf1, w_err0, w_err1;
  logic r_dual_grant_err;

  request_channel #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_ch0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_job   (i_job0),
    .i_grant (i_g0),
    .o_req   (o_r0),
    .o_busy  (o_busy0),
    .o_done  (o_done0),
    .o_pend  (o_pend0),
    .o_ovf   (w_ovf0),
    .o_err   (w_err0)
  );

  request_channel #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_ch1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_job   (i_job1),
    .i_grant (i_g1),
    .o_req   (o_r1),
    .o_busy  (o_busy1),
    .o_done  (o_done1),
    .o_pend  (o_pend1),
    .o_ovf   (w_ovf1),
    .o_err   (w_err1)
  );

  // The arbiter must never grant both channels at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_dual_grant_err <= 1'b0;
    else if (i_g0 && i_g1) r_dual_grant_err <= 1'b1;
  end

  assign o_ovf = w_ovf0 | w_ovf1;
  assign o_err = r_dual_grant_err | w_err0 | w_err1;

endmodule
